load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store engine, directly downstream of the width decoder. It consumes the 3-bit WidthSrc code with the ALU address and store data, and drives a word-addressed data-memory port through a req/ack handshake. Outputs are byte-lane enables and lane-shifted store data. Returned load data is aligned and sign- or zero-extended. The pipeline is stalled while an access is in flight.

## Interface
Parameters:
- ACK_TIMEOUT, 64: maximum cycles DMemReq may stay high without DMemAck before a fault; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- MemStart  in  1  access request from the memory stage; sampled only when idle
- MemWrite  in  1  1 = store, 0 = load
- WidthSrc  in  3  000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned
- ALUResult  in  32  byte address
- WriteData  in  32  store data, LSB-justified
- MemStall  out  1  hold the memory stage
- MemDone  out  1  one-cycle pulse when an access completes (load or store)
- LoadData  out  32  extended load result; valid when MemDone & ~MemWrite was latched
- AccessFault  out  1  one-cycle pulse: misaligned (macro off), illegal WidthSrc, or timeout
- DMemReq  out  1  memory request
- DMemWe  out  1  write enable
- DMemAddr  out  32  word-aligned address, bits [1:0] = 00
- DMemBE  out  4  byte-lane enables
- DMemWData  out  32  lane-shifted store data
- DMemAck  in  1  beat accepted/completed; ignored when DMemReq low
- DMemRData  in  32  read data, valid with DMemAck

## Operation
- States: IDLE, BEAT0, BEAT1, FAULT.
- IDLE with MemStart=1: latch MemWrite, WidthSrc, address, and WriteData. Compute off = addr[1:0] and size = 1/2/4 bytes.
- Illegal WidthSrc (011, 100, 111) goes to FAULT. Stores with 101/110 behave as 001/010.
- Aligned when off+size ≤ 4. Aligned access goes to BEAT0 as a single beat.
- Misaligned access: see Configuration.
- BEAT0: DMemAddr = {addr[31:2], 00}. DMemBE = size mask << off. DMemWData = WriteData << 8·off.
- BEAT1: DMemAddr = previous word + 4, with 32-bit wrap (0xFFFFFFFC → 0x00000000). DMemBE = remaining lanes from lane 0. DMemWData = WriteData >> 8·(4−off).
- DMemReq, DMemWe, DMemAddr, DMemBE, and DMemWData are held stable until DMemAck.
- Load assembly: beat0 bytes = DMemRData >> 8·off. Beat1 bytes fill the upper positions. Result is masked to size, then sign- or zero-extended per WidthSrc.
- Final ack registers LoadData (loads only; unchanged on stores), pulses MemDone, and returns to IDLE.
- Timeout counter: cleared on each new beat, increments each cycle DMemReq=1 & DMemAck=0. When it reaches ACK_TIMEOUT: drop DMemReq, go to FAULT.
- FAULT: AccessFault=1 for one cycle, MemDone=0, then IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-access drops DMemReq immediately; a late ack is ignored.
- MemStall = (IDLE & MemStart) | (state ≠ IDLE). It is combinational, so it is high in the MemStart cycle.
- Aligned access with ack in the first req cycle: MemStart at T; DMemReq at T+1; MemDone and LoadData at T+2.
- MemStall is high at T and T+1, low at T+2.
- Each extra ack wait state adds one cycle. A split access adds one beat (minimum one cycle).
- Fault on decode: MemStart at T; AccessFault at T+1; no DMemReq ever asserted.
- Timeout fault: AccessFault is high in the cycle after the ACK_TIMEOUT-th unacked cycle.
- MemStart while not IDLE is ignored. The pipeline must hold it until MemStall is low.
- Back-to-back: a new MemStart is accepted in the cycle MemDone or AccessFault is high.

## Configuration
- MISALIGNED_SPLIT_EN defined: a misaligned access (half at off=3, word at off≠0) is split into BEAT0 then BEAT1.
- MISALIGNED_SPLIT_EN undefined: a misaligned access goes to FAULT, AccessFault pulses, and no memory request is issued. The BEAT1 state is absent.

## Test plan
- Aligned lw, addr 0x100, DMemRData 0xDEADBEEF, ack in the first cycle:
  - DMemBE 1111, DMemAddr 0x100.
  - LoadData 0xDEADBEEF at T+2.
  - MemStall high for exactly 2 cycles.
- lb at 0x103, RData 0x80xxxxxx → LoadData 0xFFFFFF80. Same access as lbu → LoadData 0x00000080.
- sh 0x1234ABCD at 0x202 → one beat: DMemBE 1100, DMemWData 0xABCD0000, DMemWe=1, MemDone pulse.
- lw at 0x1FE, macro on, RData beat0 0xAABB0000 and beat1 0x0000CCDD:
  - Two beats: 0x1FC with BE 1100, then 0x200 with BE 0011.
  - LoadData 0xCCDDAABB.
- Same lw at 0x1FE with the macro off, and WidthSrc=011 → AccessFault pulse at T+1, DMemReq never high.
- ACK_TIMEOUT=4, ack never asserted:
  - DMemReq high 4 cycles, then AccessFault, then IDLE.
  - Reset asserted mid-beat → DMemReq low immediately.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: byte-lane stores, aligned and extended loads, req/ack data port.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two word beats; otherwise they fault.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemStart,
    input  logic        MemWrite,
    input  logic [2:0]  WidthSrc,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        MemStall,
    output logic        MemDone,
    output logic [31:0] LoadData,
    output logic        AccessFault,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemBE,
    output logic [31:0] DMemWData,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
        BEAT1 = 2'd2,
`endif
        FAULT = 2'd3
    } lsuState_t;

    // Lanes touched across two consecutive words: [3:0] first word, [7:4] spill into the next.
    function automatic logic [7:0] laneSpan(input logic [2:0] width, input logic [1:0] off);
        logic [7:0] m;
        case (width[1:0])
            2'b01:   m = 8'h01;
            2'b10:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] extendLoad(input logic [2:0] width, input logic [31:0] raw);
        case (width[1:0])
            2'b01:   return {{24{~width[2] & raw[7]}}, raw[7:0]};
            2'b10:   return {{16{~width[2] & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    lsuState_t        state, nextState;
    logic             writeQ;
    logic [2:0]       widthQ;
    logic [31:0]      addrQ, wdataQ;
    logic [CNT_W-1:0] ackCount;
    logic [7:0]       curSpan;
    logic [4:0]       lowShift;
    logic [31:0]      rawLoad;
    logic             startIllegal, acceptStart, curSplit, inBeat1, finalBeat, timedOut;

    assign startIllegal = WidthSrc inside {3'b011, 3'b100, 3'b111};
    // FAULT lasts one cycle and behaves like IDLE for intake, so back-to-back requests are not lost.
    assign acceptStart  = MemStart && (state == IDLE || state == FAULT);
    assign curSpan      = laneSpan(widthQ, addrQ[1:0]);
    assign curSplit     = |curSpan[7:4];
    assign lowShift     = {addrQ[1:0], 3'b000};
    assign timedOut     = DMemReq && !DMemAck && (ackCount == CNT_LAST);
    assign MemStall     = (state == IDLE && MemStart) || (state != IDLE);

`ifdef MISALIGNED_SPLIT_EN
    logic [31:0] loadLow;
    logic [5:0]  hiShift;

    assign hiShift = 6'd32 - {1'b0, lowShift};
    assign inBeat1 = (state == BEAT1);
    assign rawLoad = inBeat1 ? (loadLow | (DMemRData << hiShift)) : (DMemRData >> lowShift);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         loadLow <= '0;
        else if (state == BEAT0 && DMemAck) loadLow <= DMemRData >> lowShift;
    end
`else
    logic [7:0] startSpan;
    logic       startSplit;

    assign startSpan  = laneSpan(WidthSrc, ALUResult[1:0]);
    assign startSplit = |startSpan[7:4];
    assign inBeat1    = 1'b0;
    assign rawLoad    = DMemRData >> lowShift;
`endif

    assign finalBeat = inBeat1 || !curSplit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        nextState   = state;
        DMemReq     = 1'b0;
        DMemWe      = 1'b0;
        DMemAddr    = '0;
        DMemBE      = '0;
        DMemWData   = '0;
        AccessFault = 1'b0;
        case (state)
            IDLE, FAULT: begin
                AccessFault = (state == FAULT);
                if (!MemStart)         nextState = IDLE;
                else if (startIllegal) nextState = FAULT;
`ifdef MISALIGNED_SPLIT_EN
                else                   nextState = BEAT0;
`else
                else if (startSplit)   nextState = FAULT;
                else                   nextState = BEAT0;
`endif
            end
            BEAT0: begin
                DMemReq   = 1'b1;
                DMemWe    = writeQ;
                DMemAddr  = {addrQ[31:2], 2'b00};
                DMemBE    = curSpan[3:0];
                DMemWData = wdataQ << lowShift;
`ifdef MISALIGNED_SPLIT_EN
                if (DMemAck)       nextState = curSplit ? BEAT1 : IDLE;
`else
                if (DMemAck)       nextState = IDLE;
`endif
                else if (timedOut) nextState = FAULT;
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                DMemReq   = 1'b1;
                DMemWe    = writeQ;
                DMemAddr  = {addrQ[31:2], 2'b00} + 32'd4;
                DMemBE    = curSpan[7:4];
                DMemWData = wdataQ >> hiShift;
                if (DMemAck)       nextState = IDLE;
                else if (timedOut) nextState = FAULT;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeQ   <= 1'b0;
            widthQ   <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            ackCount <= '0;
            MemDone  <= 1'b0;
            LoadData <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            if (acceptStart) begin
                writeQ <= MemWrite;
                widthQ <= WidthSrc;
                addrQ  <= ALUResult;
                wdataQ <= WriteData;
            end
            if (!DMemReq || DMemAck) ackCount <= '0;
            else                     ackCount <= ackCount + CNT_W'(1);
            MemDone <= DMemReq && DMemAck && finalBeat;
            if (DMemReq && DMemAck && finalBeat && !writeQ)
                LoadData <= extendLoad(widthQ, rawLoad);
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (ACK_TIMEOUT=4); misaligned expectations follow MISALIGNED_SPLIT_EN.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemStart, MemWrite;
    logic [2:0]  WidthSrc;
    logic [31:0] ALUResult, WriteData;
    logic        MemStall, MemDone, AccessFault;
    logic [31:0] LoadData;
    logic        DMemReq, DMemWe;
    logic [31:0] DMemAddr, DMemWData;
    logic [3:0]  DMemBE;
    logic        DMemAck;
    logic [31:0] DMemRData;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .MemStart(MemStart), .MemWrite(MemWrite), .WidthSrc(WidthSrc),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .MemStall(MemStall), .MemDone(MemDone), .LoadData(LoadData), .AccessFault(AccessFault),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBE(DMemBE),
        .DMemWData(DMemWData), .DMemAck(DMemAck), .DMemRData(DMemRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, want);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        MemStart = 1'b1; MemWrite = we; WidthSrc = w; ALUResult = a; WriteData = d;
        #1;
    endtask

    task automatic clearStart();
        MemStart = 1'b0; MemWrite = 1'b0; WidthSrc = '0; ALUResult = '0; WriteData = '0;
    endtask

    // Starts at a negedge (cycle T); returns at the negedge of the MemDone cycle.
    task automatic runBeat(input string tag, input logic we, input logic [2:0] w,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWData, input logic [31:0] expLoad, input int waits);
        issue(we, w, a, d);
        check({tag, ".stallT"}, MemStall, 1);
        check({tag, ".reqT"}, DMemReq, 0);
        @(negedge clk);
        clearStart();
        for (int i = 0; i < waits; i++) begin
            check({tag, ".waitReq"}, DMemReq, 1);
            check({tag, ".waitAddr"}, DMemAddr, expAddr);
            @(negedge clk);
        end
        check({tag, ".req"}, DMemReq, 1);
        check({tag, ".we"}, DMemWe, we);
        check({tag, ".addr"}, DMemAddr, expAddr);
        check({tag, ".be"}, DMemBE, expBe);
        if (we) check({tag, ".wdata"}, DMemWData, expWData);
        check({tag, ".stallBeat"}, MemStall, 1);
        check({tag, ".doneEarly"}, MemDone, 0);
        DMemAck = 1'b1; DMemRData = rdata;
        @(negedge clk);
        DMemAck = 1'b0; DMemRData = '0;
        check({tag, ".done"}, MemDone, 1);
        check({tag, ".reqAfter"}, DMemReq, 0);
        check({tag, ".stallAfter"}, MemStall, 0);
        check({tag, ".load"}, LoadData, expLoad);
        check({tag, ".fault"}, AccessFault, 0);
    endtask

    task automatic faultTest(input string tag, input logic [2:0] w, input logic [31:0] a);
        issue(1'b0, w, a, 32'h0);
        check({tag, ".stallT"}, MemStall, 1);
        check({tag, ".reqT"}, DMemReq, 0);
        @(negedge clk);
        clearStart();
        check({tag, ".fault"}, AccessFault, 1);
        check({tag, ".req1"}, DMemReq, 0);
        check({tag, ".done"}, MemDone, 0);
        @(negedge clk);
        check({tag, ".faultEnd"}, AccessFault, 0);
        check({tag, ".req2"}, DMemReq, 0);
        check({tag, ".stallEnd"}, MemStall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; DMemAck = 1'b0; DMemRData = '0;
        clearStart();
        repeat (2) @(negedge clk);
        check("rst.ctrl", {MemStall, MemDone, AccessFault, DMemReq, DMemWe, DMemBE}, 0);
        check("rst.addr", DMemAddr, 0);
        check("rst.wdata", DMemWData, 0);
        check("rst.load", LoadData, 0);
        reset = 1'b0;
        @(negedge clk);

        runBeat("lw", 1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        // Accepted in the MemDone cycle itself.
        runBeat("swB2B", 1'b1, 3'b000, 32'h104, 32'h55AA1234, 32'h0, 32'h104, 4'hF, 32'h55AA1234, 32'hDEADBEEF, 0);
        @(negedge clk);
        runBeat("lb", 1'b0, 3'b001, 32'h103, 32'h0, 32'h80123456, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 0);
        @(negedge clk);
        runBeat("lbu", 1'b0, 3'b101, 32'h103, 32'h0, 32'h80123456, 32'h100, 4'h8, 32'h0, 32'h00000080, 1);
        @(negedge clk);
        runBeat("lh", 1'b0, 3'b010, 32'h102, 32'h0, 32'h80010000, 32'h100, 4'hC, 32'h0, 32'hFFFF8001, 0);
        @(negedge clk);
        runBeat("lhu", 1'b0, 3'b110, 32'h100, 32'h0, 32'h00009ABC, 32'h100, 4'h3, 32'h0, 32'h00009ABC, 2);
        @(negedge clk);
        runBeat("sh", 1'b1, 3'b010, 32'h202, 32'h1234ABCD, 32'h0, 32'h200, 4'hC, 32'hABCD0000, 32'h00009ABC, 0);
        @(negedge clk);
        runBeat("sb", 1'b1, 3'b001, 32'h301, 32'h123456EE, 32'h0, 32'h300, 4'h2, 32'h3456EE00, 32'h00009ABC, 1);
        @(negedge clk);

`ifdef MISALIGNED_SPLIT_EN
        issue(1'b0, 3'b000, 32'h1FE, 32'h0);
        check("split.stallT", MemStall, 1);
        @(negedge clk);
        clearStart();
        check("split.req0", DMemReq, 1);
        check("split.addr0", DMemAddr, 32'h1FC);
        check("split.be0", DMemBE, 4'hC);
        DMemAck = 1'b1; DMemRData = 32'hAABB0000;
        @(negedge clk);
        check("split.req1", DMemReq, 1);
        check("split.addr1", DMemAddr, 32'h200);
        check("split.be1", DMemBE, 4'h3);
        check("split.doneEarly", MemDone, 0);
        DMemRData = 32'h0000CCDD;
        @(negedge clk);
        DMemAck = 1'b0; DMemRData = '0;
        check("split.done", MemDone, 1);
        check("split.load", LoadData, 32'hCCDDAABB);
        check("split.req", DMemReq, 0);
`else
        faultTest("misalign", 3'b000, 32'h1FE);
`endif
        @(negedge clk);
        faultTest("illegal", 3'b011, 32'h100);
        @(negedge clk);

        // Never acked: request holds for ACK_TIMEOUT cycles, then a one-cycle fault.
        issue(1'b0, 3'b000, 32'h300, 32'h0);
        @(negedge clk);
        clearStart();
        for (int i = 0; i < 4; i++) begin
            check("tmo.req", DMemReq, 1);
            check("tmo.fault", AccessFault, 0);
            @(negedge clk);
        end
        check("tmo.faultHi", AccessFault, 1);
        check("tmo.reqDrop", DMemReq, 0);
        @(negedge clk);
        check("tmo.faultLo", AccessFault, 0);
        check("tmo.idle", MemStall, 0);
        check("tmo.done", MemDone, 0);
        @(negedge clk);

        // Reset mid-beat drops the request at once; a late ack must be ignored.
        issue(1'b0, 3'b000, 32'h400, 32'h0);
        @(negedge clk);
        clearStart();
        check("rstMid.req", DMemReq, 1);
        #2 reset = 1'b1;
        #1 check("rstMid.reqDrop", DMemReq, 0);
        DMemAck = 1'b1; DMemRData = 32'h12345678;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstMid.lateReq", DMemReq, 0);
        check("rstMid.lateDone", MemDone, 0);
        check("rstMid.load", LoadData, 0);
        DMemAck = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
